seg_display_controller: RTL and testbench



---
 rtl/seg_chars_pkg.sv | 25 ++
 rtl/seg_char_decoder.sv | 33 +++
 rtl/seg_display_controller.sv | 113 +++++++++++
 tb/tb_seg_display_controller.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_chars_pkg.sv
// Character codes and segment constants shared by the display controller and the game-mode blocks.
package seg_chars_pkg;

    typedef logic [4:0] char_code_t;
    typedef logic [6:0] seg_pattern_t;

    localparam int NUM_DIGITS = 4;

    localparam char_code_t C_S      = 5'd5;
    localparam char_code_t C_g      = 5'd9;
    localparam char_code_t C_HYPHEN = 5'd10;
    localparam char_code_t C_E      = 5'd11;
    localparam char_code_t C_r      = 5'd12;
    localparam char_code_t C_L      = 5'd13;
    localparam char_code_t C_o      = 5'd17;
    localparam char_code_t C_b      = 5'd18;
    localparam char_code_t C_d      = 5'd19;
    localparam char_code_t C_BLANK  = 5'd31;

    // Active-high gfedcba pattern for a dark digit; the pins see its inverse.
    localparam seg_pattern_t SEG_BLANK_PATTERN = 7'h00;
    localparam seg_pattern_t SEG_ALL_OFF       = 7'h7F;
    localparam logic [3:0]   AN_ALL_OFF        = 4'hF;

endpackage

// File: rtl/seg_char_decoder.sv
// Combinational character decoder: 5-bit code to active-high gfedcba pattern.
module seg_char_decoder
    import seg_chars_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_BLANK_PATTERN;
        case (code)
            5'd0:     pattern = 7'h3F;
            5'd1:     pattern = 7'h06;
            5'd2:     pattern = 7'h5B;
            5'd3:     pattern = 7'h4F;
            5'd4:     pattern = 7'h66;
            C_S:      pattern = 7'h6D;
            5'd6:     pattern = 7'h7D;
            5'd7:     pattern = 7'h07;
            5'd8:     pattern = 7'h7F;
            C_g:      pattern = 7'h6F;
            C_HYPHEN: pattern = 7'h40;
            C_E:      pattern = 7'h79;
            C_r:      pattern = 7'h50;
            C_L:      pattern = 7'h38;
            C_o:      pattern = 7'h5C;
            C_b:      pattern = 7'h7C;
            C_d:      pattern = 7'h5E;
            default:  pattern = SEG_BLANK_PATTERN;
        endcase
    end

endmodule

// File: rtl/seg_display_controller.sv
// 4-digit multiplexed 7-segment driver with once-per-frame snapshot of seg_data.
// Optional anode-off guard at the start of each digit slot: define SEG_GHOST_GUARD_EN.
module seg_display_controller
    import seg_chars_pkg::*;
#(
    parameter int DIGIT_PERIOD = 100_000,
    parameter int GUARD_CYCLES = 1_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] seg_data,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int CW = $clog2(DIGIT_PERIOD);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_PERIOD - 1);
    localparam logic [CW-1:0] GUARD_END = CW'(GUARD_CYCLES);

`ifdef SEG_GHOST_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif

    logic [CW-1:0]                   cnt_q, cnt_d;
    logic [1:0]                      digit_idx_q, digit_idx_d;
    logic [NUM_DIGITS-1:0][4:0]      snap_q, snap_d;
    logic                            load_pending_q, load_pending_d;
    logic                            loaded_q, loaded_d;
    logic [3:0]                      an_q, an_d;
    logic [6:0]                      seg_q, seg_d;
    logic                            frame_tick_q, frame_tick_d;

    logic       slot_end;
    logic       load;
    logic       guard_active;
    logic [4:0] cur_code;
    logic [6:0] cur_pattern;

    assign cur_code = snap_q[digit_idx_q];

    seg_char_decoder u_decoder (
        .code    (cur_code),
        .pattern (cur_pattern)
    );

    always_comb begin
        slot_end     = (cnt_q == CNT_LAST);
        load         = load_pending_q || (slot_end && (digit_idx_q == 2'd3));
        guard_active = GUARD_EN && (cnt_q < GUARD_END);

        cnt_d          = cnt_q;
        digit_idx_d    = digit_idx_q;
        snap_d         = snap_q;
        load_pending_d = 1'b0;
        loaded_d       = load;
        frame_tick_d   = loaded_q;

        if (load) begin
            snap_d = seg_data;
        end

        // The scan stays parked at digit 0, count 0 until the first snapshot is in,
        // so the first frame has the same shape as every later one.
        if (!load_pending_q) begin
            if (slot_end) begin
                cnt_d       = '0;
                digit_idx_d = digit_idx_q + 2'd1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        if (load_pending_q || guard_active) begin
            an_d  = AN_ALL_OFF;
            seg_d = SEG_ALL_OFF;
        end else begin
            an_d  = ~(4'b0001 << digit_idx_q);
            seg_d = ~cur_pattern;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q          <= '0;
            digit_idx_q    <= 2'd0;
            snap_q         <= {NUM_DIGITS{C_BLANK}};
            load_pending_q <= 1'b1;
            loaded_q       <= 1'b0;
            an_q           <= AN_ALL_OFF;
            seg_q          <= SEG_ALL_OFF;
            frame_tick_q   <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            digit_idx_q    <= digit_idx_d;
            snap_q         <= snap_d;
            load_pending_q <= load_pending_d;
            loaded_q       <= loaded_d;
            an_q           <= an_d;
            seg_q          <= seg_d;
            frame_tick_q   <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = 1'b1;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_display_controller.sv
// Bench for seg_display_controller: randomized seg_data against a frame-level reference model.
module tb_seg_display_controller;

    localparam int DP = 8;
    localparam int GC = 2;
    localparam int FRAME = 4 * DP;

`ifdef SEG_GHOST_GUARD_EN
    localparam bit GUARD_ON = 1'b1;
`else
    localparam bit GUARD_ON = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [19:0] seg_data;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    int checks = 0;
    int passes = 0;

    // k: clock edges since reset was last released (0 = the edge that takes the first snapshot)
    int          k = -1;
    logic [19:0] frames[$];
    logic [6:0]  font[32];

    seg_display_controller #(
        .DIGIT_PERIOD (DP),
        .GUARD_CYCLES (GC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .seg_data   (seg_data),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (reset) begin
            k = -1;
            frames.delete();
        end else begin
            k = k + 1;
            if (k % FRAME == 0) frames.push_back(seg_data);
        end
    end

    // Outputs expected after edge kk: display cycle j=kk-1 shows digit j/DP mod 4 of frame j/FRAME.
    function automatic void model(input int kk, output logic [3:0] e_an,
                                  output logic [6:0] e_seg, output logic e_ft);
        int j, d, p, f;
        logic [19:0] w;
        logic [4:0]  c;
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_ft  = 1'b0;
        if (kk >= 1) begin
            j = kk - 1;
            d = (j / DP) % 4;
            p = j % DP;
            f = j / FRAME;
            w = frames[f];
            c = w[d*5 +: 5];
            e_ft = (j % FRAME == 0);
            if (!(GUARD_ON && p < GC)) begin
                e_an  = ~(4'b0001 << d);
                e_seg = ~font[c];
            end
        end
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        seg_data = 20'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (an !== 4'hF) $display("FAIL reset_an: got %b expected 1111", an); else passes++;
            checks++; if (seg !== 7'h7F) $display("FAIL reset_seg: got %h expected 7f", seg); else passes++;
            checks++; if (dp !== 1'b1) $display("FAIL reset_dp: got %b expected 1", dp); else passes++;
            checks++; if (frame_tick !== 1'b0) $display("FAIL reset_ft: got %b expected 0", frame_tick); else passes++;
        end
    endtask

    task automatic test_static_scan();
        logic [3:0] e_an; logic [6:0] e_seg; logic e_ft;
        int ticks = 0;
        seg_data = {5'd0, 5'd1, 5'd2, 5'd3};
        reset = 1'b0;
        for (int i = 0; i < 2 * FRAME + 2; i++) begin
            @(negedge clk);
            model(k, e_an, e_seg, e_ft);
            if (frame_tick === 1'b1) ticks++;
            checks++; if (an !== e_an) $display("FAIL scan_an k=%0d: got %b expected %b", k, an, e_an); else passes++;
            checks++; if (seg !== e_seg) $display("FAIL scan_seg k=%0d: got %h expected %h", k, seg, e_seg); else passes++;
            checks++; if (frame_tick !== e_ft) $display("FAIL scan_ft k=%0d: got %b expected %b", k, frame_tick, e_ft); else passes++;
            checks++; if (dp !== 1'b1) $display("FAIL scan_dp k=%0d: got %b expected 1", k, dp); else passes++;
        end
        // edges 1, 33 and 65 carry a tick within these 66 cycles
        checks++; if (ticks !== 3) $display("FAIL scan_tick_count: got %0d expected 3", ticks); else passes++;
    endtask

    task automatic test_tear_free();
        logic [3:0] e_an; logic [6:0] e_seg; logic e_ft;
        logic changed = 1'b0;
        int   chg_frame = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            model(k, e_an, e_seg, e_ft);
            checks++; if (an !== e_an) $display("FAIL tear_an k=%0d: got %b expected %b", k, an, e_an); else passes++;
            checks++; if (seg !== e_seg) $display("FAIL tear_seg k=%0d: got %h expected %h", k, seg, e_seg); else passes++;
            checks++; if (frame_tick !== e_ft) $display("FAIL tear_ft k=%0d: got %b expected %b", k, frame_tick, e_ft); else passes++;
            if (changed && (k - 1) / FRAME == chg_frame + 1 && ((k - 1) / DP) % 4 == 3 && (k - 1) % DP == DP - 1) begin
                checks++;
                if (seg !== ~7'h40) $display("FAIL tear_new_d3: got %h expected %h", seg, ~7'h40); else passes++;
            end
            if (changed && (k - 1) / FRAME == chg_frame && ((k - 1) / DP) % 4 == 2 && (k - 1) % DP == DP - 1) begin
                checks++;
                if (seg !== ~7'h06) $display("FAIL tear_old_d2: got %h expected %h", seg, ~7'h06); else passes++;
            end
            if (!changed && k >= 1 && ((k - 1) / DP) % 4 == 1 && (k - 1) % DP == 3) begin
                seg_data  = {5'd10, 5'd11, 5'd12, 5'd12};
                changed   = 1'b1;
                chg_frame = (k - 1) / FRAME;
            end
        end
        checks++; if (!changed) $display("FAIL tear_wait: got timeout expected digit 1 lit"); else passes++;
    endtask

    task automatic test_undefined_codes();
        logic [3:0] e_an; logic [6:0] e_seg; logic e_ft;
        seg_data = {5'd14, 5'd22, 5'd31, 5'd30};
        for (int i = 0; i < 2 * FRAME + 8; i++) begin
            @(negedge clk);
            model(k, e_an, e_seg, e_ft);
            checks++; if (an !== e_an) $display("FAIL undef_an k=%0d: got %b expected %b", k, an, e_an); else passes++;
            if (i >= FRAME + 1) begin
                checks++; if (seg !== 7'h7F) $display("FAIL undef_seg k=%0d: got %h expected 7f", k, seg); else passes++;
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [3:0] e_an; logic [6:0] e_seg; logic e_ft;
        logic [19:0] nd;
        logic found = 1'b0;
        for (int i = 0; i < FRAME + 2 && !found; i++) begin
            @(negedge clk);
            if (k >= 0 && k % FRAME == 2 * DP + 5) found = 1'b1;
        end
        checks++; if (!found) $display("FAIL midrst_wait: got timeout expected digit 2 cnt 5"); else passes++;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (an !== 4'hF) $display("FAIL midrst_an: got %b expected 1111", an); else passes++;
        checks++; if (seg !== 7'h7F) $display("FAIL midrst_seg: got %h expected 7f", seg); else passes++;
        nd = {5'd19, 5'd17, 5'd13, 5'd8};
        seg_data = nd;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (an !== 4'hF) $display("FAIL midrst_e0_an: got %b expected 1111", an); else passes++;
        @(negedge clk);
        e_an  = GUARD_ON ? 4'hF : 4'b1110;
        e_seg = GUARD_ON ? 7'h7F : ~7'h7F;
        checks++; if (an !== e_an) $display("FAIL midrst_e1_an: got %b expected %b", an, e_an); else passes++;
        checks++; if (seg !== e_seg) $display("FAIL midrst_e1_seg: got %h expected %h", seg, e_seg); else passes++;
        checks++; if (frame_tick !== 1'b1) $display("FAIL midrst_e1_ft: got %b expected 1", frame_tick); else passes++;
        for (int i = 0; i < FRAME + 4; i++) begin
            @(negedge clk);
            model(k, e_an, e_seg, e_ft);
            checks++; if (an !== e_an) $display("FAIL midrst_an k=%0d: got %b expected %b", k, an, e_an); else passes++;
            checks++; if (seg !== e_seg) $display("FAIL midrst_seg k=%0d: got %h expected %h", k, seg, e_seg); else passes++;
        end
    endtask

    task automatic test_boundary_write();
        logic [3:0] e_an; logic [6:0] e_seg; logic e_ft;
        logic found = 1'b0;
        logic [19:0] nd;
        for (int i = 0; i < FRAME + 2 && !found; i++) begin
            @(negedge clk);
            if (k >= 0 && k % FRAME == FRAME - 1) found = 1'b1;
        end
        checks++; if (!found) $display("FAIL bnd_wait: got timeout expected frame end"); else passes++;
        nd = {5'd3, 5'd4, 5'd6, 5'd7};
        seg_data = nd;
        for (int i = 0; i < DP + 1; i++) begin
            @(negedge clk);
            model(k, e_an, e_seg, e_ft);
            checks++; if (an !== e_an) $display("FAIL bnd_an k=%0d: got %b expected %b", k, an, e_an); else passes++;
            checks++; if (seg !== e_seg) $display("FAIL bnd_seg k=%0d: got %h expected %h", k, seg, e_seg); else passes++;
            checks++; if (frame_tick !== e_ft) $display("FAIL bnd_ft k=%0d: got %b expected %b", k, frame_tick, e_ft); else passes++;
        end
        // last cycle of digit 0's slot, past any guard
        checks++; if (seg !== ~7'h07) $display("FAIL bnd_d0: got %h expected %h", seg, ~7'h07); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] e_an; logic [6:0] e_seg; logic e_ft;
        for (int i = 0; i < 5 * FRAME; i++) begin
            @(negedge clk);
            model(k, e_an, e_seg, e_ft);
            checks++; if (an !== e_an) $display("FAIL b2b_an k=%0d: got %b expected %b", k, an, e_an); else passes++;
            checks++; if (seg !== e_seg) $display("FAIL b2b_seg k=%0d: got %h expected %h", k, seg, e_seg); else passes++;
            checks++; if (frame_tick !== e_ft) $display("FAIL b2b_ft k=%0d: got %b expected %b", k, frame_tick, e_ft); else passes++;
            if (i < 2 * FRAME || $urandom_range(0, 3) == 0) seg_data = 20'($urandom);
        end
    endtask

    initial begin
        reset    = 1'b1;
        seg_data = '0;
        foreach (font[i]) font[i] = 7'h00;
        font[0]  = 7'h3F; font[1]  = 7'h06; font[2]  = 7'h5B; font[3]  = 7'h4F;
        font[4]  = 7'h66; font[5]  = 7'h6D; font[6]  = 7'h7D; font[7]  = 7'h07;
        font[8]  = 7'h7F; font[9]  = 7'h6F; font[10] = 7'h40; font[11] = 7'h79;
        font[12] = 7'h50; font[13] = 7'h38; font[17] = 7'h5C; font[18] = 7'h7C;
        font[19] = 7'h5E;

        test_reset();
        test_static_scan();
        test_tear_free();
        test_undefined_codes();
        test_reset_mid_scan();
        test_boundary_write();
        test_back_to_back();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
